// File: rtl/ppi_pkg.sv
// Shared types and elaboration helpers for the PPI transmit framer.
// Holds the framer state encoding, the FIFO level width and the configuration check.
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Level needs one extra bit so that a completely full FIFO is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(input int frame_len, input int fifo_depth,
                                input int start_level, input int gap_cycles);
    return (frame_len >= 1) && (start_level >= 1) && (start_level <= frame_len) &&
           (start_level <= fifo_depth) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0) && (gap_cycles >= 0);
  endfunction

endpackage

// File: rtl/ppi_tx_fifo.sv
// Synchronous input FIFO for the PPI framer with registered ready and occupancy.
// No push/pop pass-through: a word pushed into an empty FIFO is poppable one cycle later.
module ppi_tx_fifo
  import ppi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int LVL_W  = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              ready,
  output logic [LVL_W-1:0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              ready_r;
  logic [LVL_W-1:0]  level_next_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  // ready_r is registered and always equals !full, so gating push with it blocks writes at full.
  assign push_ok_s = push && ready_r;
  assign pop_ok_s  = pop && (level_r != {LVL_W{1'b0}});

  // Occupancy for the next cycle.
  always_comb begin
    level_next_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_next_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, occupancy and ready; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      level_r <= level_next_s;
      ready_r <= (level_next_s != LVL_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign empty = (level_r == {LVL_W{1'b0}});
  assign ready = ready_r;
  assign level = level_r;

endmodule

// File: rtl/ppi_tx_framer.sv
// PPI transmitter: buffers input words and sends them as fixed-length frames with a
// one-cycle frame sync on the first word, an inter-frame gap and sticky underrun flag.
module ppi_tx_framer
  import ppi_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                FRAME_LEN   = 16,
  parameter int                FIFO_DEPTH  = 32,
  parameter int                START_LEVEL = 16,
  parameter int                GAP_CYCLES  = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = {DATA_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        s_valid,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        s_ready,
  output logic                        ppi_clk,
  output logic                        ppi_fs,
  output logic [DATA_W-1:0]           ppi_data,
  output logic                        busy,
  output logic                        underrun,
  input  logic                        clr_underrun,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int LVL_W = level_w(FIFO_DEPTH);
  localparam int CW    = $clog2(FRAME_LEN + 1);
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  if (!cfg_ok(FRAME_LEN, FIFO_DEPTH, START_LEVEL, GAP_CYCLES)) begin : g_bad_cfg
    $error("ppi_tx_framer: illegal parameter combination");
  end

  state_e            state_r, state_next_s;
  logic [CW-1:0]     cnt_r, cnt_next_s;
  logic [GW-1:0]     gcnt_r, gcnt_next_s;
  logic              fs_r, fs_next_s;
  logic [DATA_W-1:0] data_r, data_next_s;
  logic              underrun_r, underrun_next_s;
  logic              busy_r;
  logic              pop_s;
  logic [DATA_W-1:0] fifo_rdata_s;
  logic              fifo_empty_s;
  logic [LVL_W-1:0]  fifo_level_s;

  ppi_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .ready (s_ready),
    .level (fifo_level_s)
  );

  // Next-state, FIFO pop and next output values for the framer.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    gcnt_next_s     = gcnt_r;
    fs_next_s       = 1'b0;
    data_next_s     = IDLE_WORD;
    pop_s           = 1'b0;
    underrun_next_s = clr_underrun ? 1'b0 : underrun_r;
    case (state_r)
      IDLE: begin
        if (enable && (fifo_level_s >= LVL_W'(START_LEVEL))) begin
          pop_s        = 1'b1;
          data_next_s  = fifo_rdata_s;
          fs_next_s    = 1'b1;
          cnt_next_s   = CW'(1);
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (cnt_r == CW'(FRAME_LEN)) begin
          if (GAP_CYCLES > 0) begin
            state_next_s = GAP;
            gcnt_next_s  = GW'(1);
          end else begin
            state_next_s = IDLE;
          end
        end else if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          data_next_s = fifo_rdata_s;
          cnt_next_s  = cnt_r + CW'(1);
        end else begin
          // Missing word: keep the slot so the frame length seen by the DSP is unchanged.
          underrun_next_s = 1'b1;
          cnt_next_s      = cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (gcnt_r == GW'(GAP_CYCLES)) begin
          state_next_s = IDLE;
        end else begin
          gcnt_next_s = gcnt_r + GW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, counters and all registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      gcnt_r     <= {GW{1'b0}};
      fs_r       <= 1'b0;
      data_r     <= IDLE_WORD;
      underrun_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      gcnt_r     <= gcnt_next_s;
      fs_r       <= fs_next_s;
      data_r     <= data_next_s;
      underrun_r <= underrun_next_s;
      busy_r     <= (state_next_s != IDLE);
    end
  end

  // DSP samples on the falling edge of clk, in the middle of the data eye.
  assign ppi_clk    = ~clk;
  assign ppi_fs     = fs_r;
  assign ppi_data   = data_r;
  assign busy       = busy_r;
  assign underrun   = underrun_r;
  assign fifo_level = fifo_level_s;

endmodule

// File: tb/tb_ppi_tx_framer.sv
// Directed self-checking bench for ppi_tx_framer (FRAME_LEN=4, GAP=2, depth 8),
// with a second START_LEVEL=2 instance for the underrun case.
module tb_ppi_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, s_valid, clr_underrun;
  logic [15:0] s_data;
  logic        s_ready, ppi_clk, ppi_fs, busy, underrun;
  logic [15:0] ppi_data;
  logic [3:0]  fifo_level;

  logic        en2, v2, clr2;
  logic [15:0] d2;
  logic        rdy2, pclk2, fs2, busy2, und2;
  logic [15:0] data2;
  logic [3:0]  lvl2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_d  [12];
  logic        exp_fs [12];

  always #5 clk = ~clk;

  ppi_tx_framer #(
    .DATA_W(16), .FRAME_LEN(4), .FIFO_DEPTH(8), .START_LEVEL(4), .GAP_CYCLES(2),
    .IDLE_WORD(16'h0000)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ppi_clk(ppi_clk), .ppi_fs(ppi_fs), .ppi_data(ppi_data),
    .busy(busy), .underrun(underrun), .clr_underrun(clr_underrun), .fifo_level(fifo_level)
  );

  ppi_tx_framer #(
    .DATA_W(16), .FRAME_LEN(4), .FIFO_DEPTH(8), .START_LEVEL(2), .GAP_CYCLES(2),
    .IDLE_WORD(16'h0000)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .s_valid(v2), .s_data(d2),
    .s_ready(rdy2), .ppi_clk(pclk2), .ppi_fs(fs2), .ppi_data(data2),
    .busy(busy2), .underrun(und2), .clr_underrun(clr2), .fifo_level(lvl2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 16'h0000; clr_underrun = 1'b0;
    en2 = 1'b0; v2 = 1'b0; d2 = 16'h0000; clr2 = 1'b0;

    // Reset then idle
    repeat (3) tick();
    chk("rst_fs", {31'd0, ppi_fs}, 32'd0);
    chk("rst_data", {16'd0, ppi_data}, 32'h0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ready_low", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // Single frame
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h1111 * 16'(i + 1);
      tick();
    end
    s_valid = 1'b0;
    chk("sf_level", {28'd0, fifo_level}, 32'd4);
    tick();
    chk("sf_w1", {16'd0, ppi_data}, 32'h1111);
    chk("sf_fs1", {31'd0, ppi_fs}, 32'd1);
    chk("sf_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("sf_w2", {16'd0, ppi_data}, 32'h2222);
    chk("sf_fs2", {31'd0, ppi_fs}, 32'd0);
    tick();
    chk("sf_w3", {16'd0, ppi_data}, 32'h3333);
    tick();
    chk("sf_w4", {16'd0, ppi_data}, 32'h4444);
    chk("sf_fs4", {31'd0, ppi_fs}, 32'd0);
    tick();
    chk("sf_idle", {16'd0, ppi_data}, 32'h0000);
    chk("sf_busy_g1", {31'd0, busy}, 32'd1);
    tick();
    chk("sf_busy_g2", {31'd0, busy}, 32'd1);
    tick();
    chk("sf_busy_fall", {31'd0, busy}, 32'd0);

    // Backpressure with enable low, then two back-to-back frames
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h00A0 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("bp_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_level", {28'd0, fifo_level}, 32'd8);
    chk("bp_no_start", {31'd0, busy}, 32'd0);
    exp_d  = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h0000, 16'h0000, 16'h0000,
               16'h00A4, 16'h00A5, 16'h00A6, 16'h00A7, 16'h0000};
    exp_fs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("b2b_data%0d", i), {16'd0, ppi_data}, {16'd0, exp_d[i]});
      chk($sformatf("b2b_fs%0d", i), {31'd0, ppi_fs}, {31'd0, exp_fs[i]});
    end
    chk("b2b_level", {28'd0, fifo_level}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("no_a8_data%0d", i), {16'd0, ppi_data}, 32'h0000);
      chk($sformatf("no_a8_fs%0d", i), {31'd0, ppi_fs}, 32'd0);
    end
    chk("b2b_underrun", {31'd0, underrun}, 32'd0);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h00D1 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("mr_w1", {16'd0, ppi_data}, 32'h00D1);
    tick();
    chk("mr_w2", {16'd0, ppi_data}, 32'h00D2);
    rst_n = 1'b0;
    tick();
    chk("mr_fs", {31'd0, ppi_fs}, 32'd0);
    chk("mr_data", {16'd0, ppi_data}, 32'h0000);
    chk("mr_level", {28'd0, fifo_level}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr_after%0d", i), {16'd0, ppi_data}, 32'h0000);
    end
    chk("mr_after_busy", {31'd0, busy}, 32'd0);

    // Underrun on START_LEVEL=2 instance
    en2 = 1'b1;
    v2 = 1'b1; d2 = 16'h0001; tick();
    d2 = 16'h0002; tick();
    v2 = 1'b0;
    tick();
    chk("ur_w1", {16'd0, data2}, 32'h0001);
    chk("ur_fs1", {31'd0, fs2}, 32'd1);
    chk("ur_flag_pre", {31'd0, und2}, 32'd0);
    tick();
    chk("ur_w2", {16'd0, data2}, 32'h0002);
    tick();
    chk("ur_w3", {16'd0, data2}, 32'h0000);
    chk("ur_flag", {31'd0, und2}, 32'd1);
    tick();
    chk("ur_w4", {16'd0, data2}, 32'h0000);
    chk("ur_busy", {31'd0, busy2}, 32'd1);
    repeat (6) tick();
    chk("ur_sticky", {31'd0, und2}, 32'd1);
    chk("ur_idle", {31'd0, busy2}, 32'd0);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("ur_clear", {31'd0, und2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
